// File: rtl/alu_pkg.sv
// ALU opcode encoding and the operation sequencer's state type.
package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_ADC = 4'h1;
  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_SBC = 4'h3;
  localparam logic [3:0] ALU_AND = 4'h4;
  localparam logic [3:0] ALU_OR  = 4'h5;
  localparam logic [3:0] ALU_XOR = 4'h6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH_A,
    ST_LATCH_B,
    ST_LATCH_F,
    ST_LATCH_OP,
    ST_READ_Y,
    ST_READ_F,
    ST_RESP
  } seq_state_t;
endpackage

// File: rtl/constants_pkg.sv
// Shared constants for the Argon datapath: default word size and the ALU bus
// command encoding driven by every bus master.
package constants_pkg;
  localparam int WORDSIZE_DEFAULT = 16;

  // com_none keeps the bus quiet; it shares no encoding with any real command
  typedef enum logic [3:0] {
    com_none    = 4'h0,
    com_latchA  = 4'h1,
    com_latchB  = 4'h2,
    com_latchF  = 4'h3,
    com_latchOp = 4'h4,
    com_outputY = 4'h5,
    com_outputF = 4'h6
  } command_t;
endpackage

// File: rtl/alu_sequencer.sv
// Runs one ALU operation over the command bus: load A, B, flags and opcode,
// read back result and flags, then hold them until the requester takes them.
module alu_sequencer
  import constants_pkg::*;
  import alu_pkg::*;
#(
  parameter bit LOAD_FLAGS = 1'b1,
  parameter int WORDSIZE   = WORDSIZE_DEFAULT
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  input  logic                i_ReqValid,
  output logic                o_ReqReady,
  input  logic [3:0]          i_ReqOp,
  input  logic [WORDSIZE-1:0] i_ReqA,
  input  logic [WORDSIZE-1:0] i_ReqB,
  input  logic [WORDSIZE-1:0] i_ReqFlags,
  output command_t            o_Command,
  output logic                o_BusValid,
  output logic [WORDSIZE-1:0] o_BusData,
  input  logic [WORDSIZE-1:0] i_BusData,
  input  logic                i_BusValid,
  output logic                o_RespValid,
  input  logic                i_RespReady,
  output logic [WORDSIZE-1:0] o_RespY,
  output logic [WORDSIZE-1:0] o_RespFlags,
  output logic                o_RespErr
);
  seq_state_t          state;
  logic [3:0]          req_op;
  logic [WORDSIZE-1:0] req_a;
  logic [WORDSIZE-1:0] req_b;
  logic [WORDSIZE-1:0] req_flags;
  logic [WORDSIZE-1:0] resp_y;
  logic [WORDSIZE-1:0] resp_flags;
  logic                resp_err;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= ST_IDLE;
      req_op     <= '0;
      req_a      <= '0;
      req_b      <= '0;
      req_flags  <= '0;
      resp_y     <= '0;
      resp_flags <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_ReqValid) begin
            req_op    <= i_ReqOp;
            req_a     <= i_ReqA;
            req_b     <= i_ReqB;
            req_flags <= i_ReqFlags;
            resp_err  <= 1'b0;
            state     <= ST_LATCH_A;
          end
        end
        ST_LATCH_A:  state <= ST_LATCH_B;
        ST_LATCH_B:  state <= LOAD_FLAGS ? ST_LATCH_F : ST_LATCH_OP;
        ST_LATCH_F:  state <= ST_LATCH_OP;
        ST_LATCH_OP: state <= ST_READ_Y;
        // A read cycle without the ALU's valid strobe marks the whole response bad
        ST_READ_Y: begin
          resp_y <= i_BusData;
          if (!i_BusValid) resp_err <= 1'b1;
          state <= ST_READ_F;
        end
        ST_READ_F: begin
          resp_flags <= i_BusData;
          if (!i_BusValid) resp_err <= 1'b1;
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (i_RespReady) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bus drive is decoded straight from state so reset silences it at once
  always_comb begin
    o_Command  = com_none;
    o_BusValid = 1'b0;
    o_BusData  = '0;
    case (state)
      ST_LATCH_A: begin
        o_Command  = com_latchA;
        o_BusValid = 1'b1;
        o_BusData  = req_a;
      end
      ST_LATCH_B: begin
        o_Command  = com_latchB;
        o_BusValid = 1'b1;
        o_BusData  = req_b;
      end
      ST_LATCH_F: begin
        o_Command  = com_latchF;
        o_BusValid = 1'b1;
        o_BusData  = req_flags;
      end
      ST_LATCH_OP: begin
        o_Command  = com_latchOp;
        o_BusValid = 1'b1;
        o_BusData  = WORDSIZE'(req_op);
      end
      ST_READ_Y: o_Command = com_outputY;
      ST_READ_F: o_Command = com_outputF;
      default: ;
    endcase
  end

  assign o_ReqReady  = (state == ST_IDLE);
  assign o_RespValid = (state == ST_RESP);
  assign o_RespY     = resp_y;
  assign o_RespFlags = resp_flags;
  assign o_RespErr   = resp_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: two instances (flags loaded / not loaded), each with
// a behavioural ALU on its bus and a transaction-level model checked every cycle.
module tb_alu_sequencer;
  import constants_pkg::*;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic        req_valid[2];
  logic        req_ready[2];
  logic [3:0]  req_op[2];
  logic [15:0] req_a[2];
  logic [15:0] req_b[2];
  logic [15:0] req_f[2];
  command_t    cmd[2];
  logic        bus_valid_o[2];
  logic [15:0] bus_data_o[2];
  logic [15:0] bus_data_i[2];
  logic        bus_valid_i[2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [15:0] resp_y[2];
  logic [15:0] resp_f[2];
  logic        resp_err[2];
  logic        bad_ry[2];

  task automatic chk(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got 0x%0h, want 0x%0h", inst, name, act, exp);
    end
  endtask

  task automatic fail(input int inst, input string name);
    vectors++;
    errors++;
    $display("FAIL u%0d %s: bound expired", inst, name);
  endtask

  // ALU behaviour: {result, flags}; flags = carry,zero,neg,ovf,less,borrow in bits 0..5
  function automatic logic [31:0] alu_eval(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] fin);
    logic [16:0] s;
    logic [15:0] y;
    logic [15:0] fl;
    logic        cin;
    logic        ovf;
    cin = fin[0];
    ovf = 1'b0;
    case (op)
      ALU_ADD: s = {1'b0, a} + {1'b0, b};
      ALU_ADC: s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
      ALU_SUB: s = {1'b0, a} - {1'b0, b};
      ALU_SBC: s = {1'b0, a} - {1'b0, b} - {16'b0, cin};
      ALU_AND: s = {1'b0, a & b};
      ALU_OR:  s = {1'b0, a | b};
      ALU_XOR: s = {1'b0, a ^ b};
      default: s = '0;
    endcase
    y = s[15:0];
    if (op == ALU_ADD || op == ALU_ADC) ovf = (a[15] == b[15]) && (y[15] != a[15]);
    if (op == ALU_SUB || op == ALU_SBC) ovf = (a[15] != b[15]) && (y[15] != a[15]);
    fl    = '0;
    fl[0] = s[16];
    fl[1] = (y == 16'h0);
    fl[2] = y[15];
    fl[3] = ovf;
    fl[4] = (a < b);
    fl[5] = ({1'b0, a} < ({1'b0, b} + {16'b0, cin}));
    return {y, fl};
  endfunction

  function automatic logic [15:0] eval_y(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] fin);
    logic [31:0] r;
    r = alu_eval(op, a, b, fin);
    return r[31:16];
  endfunction

  function automatic logic [15:0] eval_f(input logic [3:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] fin);
    logic [31:0] r;
    r = alu_eval(op, a, b, fin);
    return r[15:0];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam bit LF  = (g == 0);
    localparam int LEN = LF ? 6 : 5;

    alu_sequencer #(.LOAD_FLAGS(LF), .WORDSIZE(16)) u_dut (
      .i_Clk(clk), .i_Reset(rst),
      .i_ReqValid(req_valid[g]), .o_ReqReady(req_ready[g]),
      .i_ReqOp(req_op[g]), .i_ReqA(req_a[g]), .i_ReqB(req_b[g]), .i_ReqFlags(req_f[g]),
      .o_Command(cmd[g]), .o_BusValid(bus_valid_o[g]), .o_BusData(bus_data_o[g]),
      .i_BusData(bus_data_i[g]), .i_BusValid(bus_valid_i[g]),
      .o_RespValid(resp_valid[g]), .i_RespReady(resp_ready[g]),
      .o_RespY(resp_y[g]), .o_RespFlags(resp_f[g]), .o_RespErr(resp_err[g])
    );

    // Downstream ALU on the command bus
    logic [15:0] alu_a, alu_b, alu_f, alu_y;
    assign bus_valid_i[g] = ((cmd[g] == com_outputY) && !bad_ry[g]) || (cmd[g] == com_outputF);
    assign bus_data_i[g]  = (cmd[g] == com_outputY) ? alu_y :
                            (cmd[g] == com_outputF) ? alu_f : 16'h0;
    always_ff @(posedge clk) begin
      if (rst) begin
        alu_a <= '0;
        alu_b <= '0;
        alu_f <= '0;
        alu_y <= '0;
      end else if (bus_valid_o[g]) begin
        case (cmd[g])
          com_latchA: alu_a <= bus_data_o[g];
          com_latchB: alu_b <= bus_data_o[g];
          com_latchF: alu_f <= bus_data_o[g];
          com_latchOp: begin
            alu_y <= eval_y(bus_data_o[g][3:0], alu_a, alu_b, alu_f);
            alu_f <= eval_f(bus_data_o[g][3:0], alu_a, alu_b, alu_f);
          end
          default: ;
        endcase
      end
    end

    // Transaction model: m_n counts cycles since accept; RESP once it passes LEN
    logic        m_busy, m_err;
    int          m_n;
    logic [3:0]  m_op;
    logic [15:0] m_a, m_b, m_f, m_y, m_alu_f;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_busy  <= 1'b0;
        m_n     <= 0;
        m_alu_f <= '0;
      end else if (!m_busy) begin
        if (req_valid[g]) begin
          m_busy  <= 1'b1;
          m_n     <= 1;
          m_op    <= req_op[g];
          m_a     <= req_a[g];
          m_b     <= req_b[g];
          m_f     <= req_f[g];
          m_y     <= eval_y(req_op[g], req_a[g], req_b[g], LF ? req_f[g] : m_alu_f);
          m_alu_f <= eval_f(req_op[g], req_a[g], req_b[g], LF ? req_f[g] : m_alu_f);
          m_err   <= bad_ry[g];
        end
      end else if (m_n <= LEN) begin
        m_n <= m_n + 1;
      end else if (resp_ready[g]) begin
        m_busy <= 1'b0;
        m_n    <= 0;
      end
    end

    function automatic int step_kind();
      if (!m_busy || m_n > LEN) return 0;
      return (LF || m_n < 3) ? m_n : m_n + 1;
    endfunction

    function automatic command_t exp_cmd();
      case (step_kind())
        1: return com_latchA;
        2: return com_latchB;
        3: return com_latchF;
        4: return com_latchOp;
        5: return com_outputY;
        6: return com_outputF;
        default: return com_none;
      endcase
    endfunction

    function automatic logic [15:0] exp_data();
      case (step_kind())
        1: return m_a;
        2: return m_b;
        3: return m_f;
        4: return {12'h0, m_op};
        default: return 16'h0;
      endcase
    endfunction

    always @(negedge clk) begin
      if (!rst) begin
        chk(g, "req_ready", req_ready[g], !m_busy);
        chk(g, "resp_valid", resp_valid[g], m_busy && (m_n == LEN + 1));
        chk(g, "command", cmd[g], exp_cmd());
        chk(g, "bus_valid", bus_valid_o[g], (step_kind() >= 1) && (step_kind() <= 4));
        if (step_kind() <= 4) chk(g, "bus_data", bus_data_o[g], exp_data());
        if (m_busy && m_n == LEN + 1) begin
          chk(g, "resp_y", resp_y[g], m_y);
          chk(g, "resp_flags", resp_f[g], m_alu_f);
          chk(g, "resp_err", resp_err[g], m_err);
        end
      end
    end
  end

  task automatic run_op(input int i, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] f, output int lat);
    int n;
    @(posedge clk); #1;
    req_op[i] = op; req_a[i] = a; req_b[i] = b; req_f[i] = f;
    req_valid[i] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready[i] && n < 50);
    if (!req_ready[i]) fail(i, "accept_timeout");
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk(i, "err_clear_on_accept", resp_err[i], 1'b0);
    end while (!resp_valid[i] && lat < 30);
  endtask

  task automatic finish_resp(input int i, input int hold);
    repeat (hold) begin
      @(negedge clk);
      chk(i, "hold_resp_valid", resp_valid[i], 1'b1);
      chk(i, "hold_req_ready", req_ready[i], 1'b0);
      chk(i, "hold_command", cmd[i], com_none);
    end
    @(posedge clk); #1 resp_ready[i] = 1'b1;
    @(posedge clk); #1 resp_ready[i] = 1'b0;
  endtask

  initial begin
    int lat, n, acc, prev;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_op[i] = 4'h0; req_a[i] = 16'h0; req_b[i] = 16'h0;
      req_f[i] = 16'h0; resp_ready[i] = 1'b0; bad_ry[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_req_ready", req_ready[i], 1'b1);
      chk(i, "rst_resp_valid", resp_valid[i], 1'b0);
      chk(i, "rst_resp_y", resp_y[i], 16'h0);
      chk(i, "rst_resp_flags", resp_f[i], 16'h0);
      chk(i, "rst_resp_err", resp_err[i], 1'b0);
      chk(i, "rst_command", cmd[i], com_none);
      chk(i, "rst_bus_valid", bus_valid_o[i], 1'b0);
      chk(i, "rst_bus_data", bus_data_o[i], 16'h0);
    end

    // Flags not loaded: carry-in comes from the ALU's own (cleared) flags
    run_op(1, ALU_ADC, 16'h0005, 16'h0003, 16'h0001, lat);
    chk(1, "adc_nolf_latency", lat, 6);
    chk(1, "adc_nolf_y", resp_y[1], 16'h0008);
    finish_resp(1, 0);
    run_op(1, ALU_SUB, 16'h0003, 16'h0005, 16'h0000, lat);
    chk(1, "sub_nolf_y", resp_y[1], 16'hFFFE);
    chk(1, "sub_nolf_flags", resp_f[1], 16'h0035);
    finish_resp(1, 0);
    run_op(1, ALU_SBC, 16'h000A, 16'h0002, 16'h0000, lat);
    chk(1, "sbc_chain_y", resp_y[1], 16'h0007);
    finish_resp(1, 0);

    run_op(0, ALU_ADD, 16'h0001, 16'hFFFF, 16'h0000, lat);
    chk(0, "add_latency", lat, 7);
    chk(0, "add_y", resp_y[0], 16'h0000);
    chk(0, "add_flags", resp_f[0], 16'h0033);
    finish_resp(0, 0);
    run_op(0, ALU_ADC, 16'h0005, 16'h0003, 16'h0001, lat);
    chk(0, "adc_y", resp_y[0], 16'h0009);
    finish_resp(0, 0);
    run_op(0, ALU_SUB, 16'h1234, 16'h0034, 16'h0000, lat);
    chk(0, "sub_y", resp_y[0], 16'h1200);
    chk(0, "sub_flags", resp_f[0], 16'h0000);
    finish_resp(0, 5);
    run_op(0, ALU_XOR, 16'hF0F0, 16'h0FF0, 16'h0000, lat);
    chk(0, "xor_y", resp_y[0], 16'hFF00);
    chk(0, "xor_flags", resp_f[0], 16'h0004);
    finish_resp(0, 1);
    run_op(0, ALU_AND, 16'h00FF, 16'hFF00, 16'h0000, lat);
    chk(0, "and_flags", resp_f[0], 16'h0032);
    finish_resp(0, 0);

    // ALU withholds its valid strobe during the result read
    @(posedge clk); #1 bad_ry[0] = 1'b1;
    run_op(0, ALU_ADD, 16'h0002, 16'h0003, 16'h0000, lat);
    chk(0, "err_set", resp_err[0], 1'b1);
    chk(0, "err_y", resp_y[0], 16'h0005);
    finish_resp(0, 0);
    @(posedge clk); #1 bad_ry[0] = 1'b0;
    run_op(0, ALU_ADD, 16'h0004, 16'h0004, 16'h0000, lat);
    chk(0, "err_cleared", resp_err[0], 1'b0);
    finish_resp(0, 0);

    // Reset in the middle of an operation
    @(posedge clk); #1;
    req_op[0] = ALU_ADD; req_a[0] = 16'h1111; req_b[0] = 16'h2222; req_f[0] = 16'h0;
    req_valid[0] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (cmd[0] != com_latchB && n < 20);
    req_valid[0] = 1'b0;
    if (cmd[0] != com_latchB) fail(0, "latchB_timeout");
    rst = 1'b1;
    #1;
    chk(0, "rst_mid_command", cmd[0], com_none);
    chk(0, "rst_mid_bus_valid", bus_valid_o[0], 1'b0);
    chk(0, "rst_mid_bus_data", bus_data_o[0], 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk(0, "no_resp_after_rst", resp_valid[0], 1'b0);
    end
    run_op(0, ALU_ADD, 16'h1111, 16'h2222, 16'h0000, lat);
    chk(0, "post_rst_latency", lat, 7);
    chk(0, "post_rst_y", resp_y[0], 16'h3333);
    finish_resp(0, 0);

    // Back-to-back requests with the response side always ready
    @(posedge clk); #1;
    resp_ready[0] = 1'b1;
    req_op[0] = ALU_OR; req_a[0] = 16'h0F00; req_b[0] = 16'h00F0; req_f[0] = 16'h0;
    req_valid[0] = 1'b1;
    acc = 0; n = 0; prev = 0;
    while (acc < 3 && n < 60) begin
      @(negedge clk);
      n++;
      if (req_ready[0]) begin
        if (acc > 0) chk(0, "accept_period", n - prev, 8);
        prev = n;
        acc++;
      end
    end
    if (acc < 3) fail(0, "throughput_timeout");
    @(posedge clk); #1 req_valid[0] = 1'b0;
    repeat (12) @(negedge clk);
    resp_ready[0] = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
